dm_bus_arbiter: RTL and testbench

//  Shares the data-side bus (data memory, TC0, TC1) between two masters: M0 = CPU MEM stage, M1 = DMA/debug port.

---
 rtl/dm_bus_arbiter_pkg.sv | 38 +++
 rtl/dm_addr_decode.sv | 45 ++++
 rtl/dm_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_bus_arbiter_pkg.sv
// rtl/dm_bus_arbiter_pkg.sv - shared FSM encoding, address map and lane-alignment helper
package dm_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DWAIT  = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // Inclusive address map; DM starts at 0 so only its upper bound is compared.
   localparam logic [31:0] DMUL    = 32'h0000_2FFF;
   localparam logic [31:0] TC0LL   = 32'h0000_7F00;
   localparam logic [31:0] TC0UL   = 32'h0000_7F0B;
   localparam logic [31:0] TC1LL   = 32'h0000_7F10;
   localparam logic [31:0] TC1UL   = 32'h0000_7F1B;
   // Timer count registers are read-only.
   localparam logic [31:0] TC0_CNT = 32'h0000_7F08;
   localparam logic [31:0] TC1_CNT = 32'h0000_7F18;

   // Byte enables must be one of the natural word/half/byte lane patterns
   // for the low address bits.
   function automatic logic be_aligned(input logic [3:0] be, input logic [1:0] a);
      logic ok;
      case (be)
         4'b1111: ok = (a == 2'd0);
         4'b0011: ok = (a == 2'd0);
         4'b1100: ok = (a == 2'd2);
         4'b0001: ok = (a == 2'd0);
         4'b0010: ok = (a == 2'd1);
         4'b0100: ok = (a == 2'd2);
         4'b1000: ok = (a == 2'd3);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dm_addr_decode.sv
// rtl/dm_addr_decode.sv - combinational slave select and access-error decode
// Ports:
//   addr_i     byte address of the candidate access
//   be_i       byte enables, lane-aligned
//   we_i       1 = store
//   sel_dm_o   data memory selected (never set together with err_o)
//   sel_tc0_o  timer 0 selected
//   sel_tc1_o  timer 1 selected
//   err_o      access must be rejected without touching any slave
module dm_addr_decode
   import dm_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [3:0]        be_i,
   input  logic              we_i,
   output logic              sel_dm_o,
   output logic              sel_tc0_o,
   output logic              sel_tc1_o,
   output logic              err_o
);

   logic in_dm;
   logic in_tc0;
   logic in_tc1;
   logic in_tc;

   always_comb begin
      in_dm  = (addr_i <= ADDR_W'(DMUL));
      in_tc0 = (addr_i >= ADDR_W'(TC0LL)) && (addr_i <= ADDR_W'(TC0UL));
      in_tc1 = (addr_i >= ADDR_W'(TC1LL)) && (addr_i <= ADDR_W'(TC1UL));
      in_tc  = in_tc0 || in_tc1;

      err_o = !(in_dm || in_tc)
              || (in_tc && (be_i != 4'b1111))
              || (we_i && ((addr_i == ADDR_W'(TC0_CNT)) || (addr_i == ADDR_W'(TC1_CNT))))
              || !be_aligned(be_i, addr_i[1:0]);

      sel_dm_o  = in_dm  && !err_o;
      sel_tc0_o = in_tc0 && !err_o;
      sel_tc1_o = in_tc1 && !err_o;
   end

endmodule

// File: rtl/dm_bus_arbiter.sv
// rtl/dm_bus_arbiter.sv - two-master round-robin arbiter for the DM / timer data bus
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   m_req, m_we                     per-master request (held until ack) and store flag
//   m0_addr/m0_wdata/m0_be          master 0 access; m1_* same for master 1
//   m_ack, m_err, m_rdata           one-cycle completion to the granted master
//   gnt_id, busy                    current bus owner, FSM not idle
//   dm_en/dm_we/dm_addr/dm_wdata/dm_be, dm_rdata   data memory port
//   tc0_we/tc1_we/tc_addr/tc_wdata, tc0_rdata/tc1_rdata   timer ports
module dm_bus_arbiter
   import dm_bus_arbiter_pkg::*;
#(
   parameter int DM_RD_LAT = 1,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        m_req,
   input  logic [1:0]        m_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m0_be,
   input  logic [3:0]        m1_be,
   output logic [1:0]        m_ack,
   output logic              m_err,
   output logic [31:0]       m_rdata,
   output logic              gnt_id,
   output logic              busy,
   output logic              dm_en,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   output logic [3:0]        dm_be,
   input  logic [31:0]       dm_rdata,
   output logic              tc0_we,
   output logic              tc1_we,
   output logic [ADDR_W-3:0] tc_addr,
   output logic [31:0]       tc_wdata,
   input  logic [31:0]       tc0_rdata,
   input  logic [31:0]       tc1_rdata
);

   // DWAIT lasts DM_RD_LAT cycles; the counter holds the extra cycles beyond the first.
   localparam logic [1:0] WAIT_INIT = 2'(DM_RD_LAT - 1);

   state_e            state_q,    state_d;
   logic              id_q,       id_d;
   logic              last_gnt_q, last_gnt_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [31:0]       wdata_q,    wdata_d;
   logic [3:0]        be_q,       be_d;
   logic              we_q,       we_d;
   logic              sel_dm_q,   sel_dm_d;
   logic              sel_tc0_q,  sel_tc0_d;
   logic              sel_tc1_q,  sel_tc1_d;
   logic              err_q,      err_d;
   logic [31:0]       rdata_q,    rdata_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;

   logic              pick_id;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_be;
   logic              req_we;
   logic              dec_sel_dm;
   logic              dec_sel_tc0;
   logic              dec_sel_tc1;
   logic              dec_err;

   // On a tie the master that did not win last time gets the bus.
   always_comb begin
      pick_id   = (m_req == 2'b11) ? ~last_gnt_q : m_req[1];
      req_addr  = pick_id ? m1_addr  : m0_addr;
      req_wdata = pick_id ? m1_wdata : m0_wdata;
      req_be    = pick_id ? m1_be    : m0_be;
      req_we    = m_we[pick_id];
   end

   dm_addr_decode #(
      .ADDR_W (ADDR_W)
   ) u_decode (
      .addr_i    (req_addr),
      .be_i      (req_be),
      .we_i      (req_we),
      .sel_dm_o  (dec_sel_dm),
      .sel_tc0_o (dec_sel_tc0),
      .sel_tc1_o (dec_sel_tc1),
      .err_o     (dec_err)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         id_q       <= 1'b0;
         last_gnt_q <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         sel_dm_q   <= 1'b0;
         sel_tc0_q  <= 1'b0;
         sel_tc1_q  <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         last_gnt_q <= last_gnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         we_q       <= we_d;
         sel_dm_q   <= sel_dm_d;
         sel_tc0_q  <= sel_tc0_d;
         sel_tc1_q  <= sel_tc1_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      last_gnt_d = last_gnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      we_d       = we_q;
      sel_dm_d   = sel_dm_q;
      sel_tc0_d  = sel_tc0_q;
      sel_tc1_d  = sel_tc1_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      wait_cnt_d = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (|m_req) begin
               state_d    = ST_ACCESS;
               id_d       = pick_id;
               last_gnt_d = pick_id;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               be_d       = req_be;
               we_d       = req_we;
               sel_dm_d   = dec_sel_dm;
               sel_tc0_d  = dec_sel_tc0;
               sel_tc1_d  = dec_sel_tc1;
               err_d      = dec_err;
               rdata_d    = '0;
            end
         end
         ST_ACCESS: begin
            // sel_* are already cleared for rejected accesses.
            if (sel_dm_q && !we_q) begin
               state_d    = ST_DWAIT;
               wait_cnt_d = WAIT_INIT;
            end else begin
               state_d = ST_RESP;
               if (sel_tc0_q && !we_q) rdata_d = tc0_rdata;
               if (sel_tc1_q && !we_q) rdata_d = tc1_rdata;
            end
         end
         ST_DWAIT: begin
            if (wait_cnt_q == 2'd0) begin
               rdata_d = dm_rdata;
               state_d = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobes and responses derive only from registered state, so an
   // asynchronous reset clears every output immediately.
   always_comb begin
      dm_en    = (state_q == ST_ACCESS) && sel_dm_q;
      dm_we    = dm_en && we_q;
      tc0_we   = (state_q == ST_ACCESS) && sel_tc0_q && we_q;
      tc1_we   = (state_q == ST_ACCESS) && sel_tc1_q && we_q;
      m_ack    = (state_q == ST_RESP) ? {id_q, ~id_q} : 2'b00;
      m_err    = (state_q == ST_RESP) && err_q;
      m_rdata  = (state_q == ST_RESP) ? rdata_q : 32'd0;
      gnt_id   = id_q;
      busy     = (state_q != ST_IDLE);
      dm_addr  = addr_q;
      dm_wdata = wdata_q;
      dm_be    = be_q;
      tc_addr  = addr_q[ADDR_W-1:2];
      tc_wdata = wdata_q;
   end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb/tb_dm_bus_arbiter.sv - scoreboard bench for dm_bus_arbiter (DM_RD_LAT 1 and 2 instances)
module tb_dm_bus_arbiter;

   localparam logic [31:0] TC0_RD = 32'h0000_7C00;
   localparam logic [31:0] TC1_RD = 32'h1111_2222;
   localparam logic [31:0] DM_BAD = 32'hBAD0_BAD0;

   typedef struct {
      int          id;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset;
   logic [1:0]  req_a, req_b, m_we;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] tc0_rdata = TC0_RD;
   logic [31:0] tc1_rdata = TC1_RD;

   logic [1:0]  ack_a, ack_b;
   logic        err_a, err_b, gnt_a, gnt_b, busy_a, busy_b;
   logic [31:0] rdata_a, rdata_b;
   logic        dm_en_a, dm_en_b, dm_we_a, dm_we_b;
   logic [31:0] dm_addr_a, dm_addr_b, dm_wdata_a, dm_wdata_b;
   logic [3:0]  dm_be_a, dm_be_b;
   logic [31:0] dm_rdata_a = DM_BAD;
   logic [31:0] dm_pipe_b  = DM_BAD;
   logic [31:0] dm_rdata_b = DM_BAD;
   logic        tc0_we_a, tc0_we_b, tc1_we_a, tc1_we_b;
   logic [29:0] tc_addr_a, tc_addr_b;
   logic [31:0] tc_wdata_a, tc_wdata_b;

   dm_bus_arbiter #(.DM_RD_LAT(1), .ADDR_W(32)) u_dut_a (
      .clk(clk), .reset(reset), .m_req(req_a), .m_we(m_we),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_be(m0_be), .m1_be(m1_be),
      .m_ack(ack_a), .m_err(err_a), .m_rdata(rdata_a), .gnt_id(gnt_a), .busy(busy_a),
      .dm_en(dm_en_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
      .dm_be(dm_be_a), .dm_rdata(dm_rdata_a),
      .tc0_we(tc0_we_a), .tc1_we(tc1_we_a), .tc_addr(tc_addr_a), .tc_wdata(tc_wdata_a),
      .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata)
   );

   dm_bus_arbiter #(.DM_RD_LAT(2), .ADDR_W(32)) u_dut_b (
      .clk(clk), .reset(reset), .m_req(req_b), .m_we(m_we),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_be(m0_be), .m1_be(m1_be),
      .m_ack(ack_b), .m_err(err_b), .m_rdata(rdata_b), .gnt_id(gnt_b), .busy(busy_b),
      .dm_en(dm_en_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
      .dm_be(dm_be_b), .dm_rdata(dm_rdata_b),
      .tc0_we(tc0_we_b), .tc1_we(tc1_we_b), .tc_addr(tc_addr_b), .tc_wdata(tc_wdata_b),
      .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata)
   );

   // DM content: word 0x0010 holds 0xDEADBEEF, everything else a tagged word address.
   function automatic logic [31:0] dm_fn(input logic [31:0] a);
      if (a[15:2] == 14'h4) return 32'hDEAD_BEEF;
      return {16'hC0DE, a[15:2], 2'b00};
   endfunction

   // Read data is valid only in the exact cycle the latency dictates.
   always @(posedge clk) begin
      dm_rdata_a <= (dm_en_a && !dm_we_a) ? dm_fn(dm_addr_a) : DM_BAD;
      dm_pipe_b  <= (dm_en_b && !dm_we_b) ? dm_fn(dm_addr_b) : DM_BAD;
      dm_rdata_b <= dm_pipe_b;
   end

   int checks   = 0;
   int failures = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Strobe observers
   int dm_cnt_a = 0, dm_we_cnt_a = 0, dm_cyc_a = -1, tc0_cnt_a = 0, tc1_cnt_a = 0;
   int dm_cnt_b = 0, dm_cyc_b = -1;
   logic [29:0] tc_addr_seen  = '0;
   logic [31:0] tc_wdata_seen = '0;

   initial forever begin
      @(negedge clk);
      if (dm_en_a === 1'b1) begin dm_cnt_a++; dm_cyc_a = cyc; end
      if (dm_we_a === 1'b1) dm_we_cnt_a++;
      if (tc0_we_a === 1'b1) begin tc0_cnt_a++; tc_addr_seen = tc_addr_a; tc_wdata_seen = tc_wdata_a; end
      if (tc1_we_a === 1'b1) tc1_cnt_a++;
      if (dm_en_b === 1'b1) begin dm_cnt_b++; dm_cyc_b = cyc; end
   end

   // Scoreboard monitors
   initial forever begin
      @(negedge clk);
      if (ack_a !== 2'b00) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_ack", {30'd0, ack_a}, 32'd0);
         end else begin
            exp_t e;
            e = q_a.pop_front();
            check("a_ack_id",    {30'd0, ack_a}, (e.id == 1) ? 32'd2 : 32'd1);
            check("a_ack_err",   {31'd0, err_a}, {31'd0, e.err});
            check("a_ack_rdata", rdata_a, e.rdata);
            check("a_ack_cycle", cyc, e.cyc);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (ack_b !== 2'b00) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_ack", {30'd0, ack_b}, 32'd0);
         end else begin
            exp_t e;
            e = q_b.pop_front();
            check("b_ack_id",    {30'd0, ack_b}, (e.id == 1) ? 32'd2 : 32'd1);
            check("b_ack_err",   {31'd0, err_b}, {31'd0, e.err});
            check("b_ack_rdata", rdata_b, e.rdata);
            check("b_ack_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic set_m(input int which, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (which == 0) begin
         m0_addr = addr; m0_wdata = wdata; m0_be = be; m_we[0] = we;
      end else begin
         m1_addr = addr; m1_wdata = wdata; m1_be = be; m_we[1] = we;
      end
   endtask

   // One request on instance A, held until its expected ack cycle.
   task automatic single_a(input int which, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic err, input logic [31:0] rdata, input int lat);
      exp_t e;
      set_m(which, we, addr, wdata, be);
      e.id = which; e.err = err; e.rdata = rdata; e.cyc = cyc + lat;
      q_a.push_back(e);
      req_a[which] = 1'b1;
      repeat (lat) @(negedge clk);
      req_a[which] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_cnt();
      dm_cnt_a = 0; dm_we_cnt_a = 0; dm_cyc_a = -1; tc0_cnt_a = 0; tc1_cnt_a = 0;
      dm_cnt_b = 0; dm_cyc_b = -1;
   endtask

   initial begin
      int t0;
      exp_t e;
      reset = 1'b0;
      req_a = 2'b00; req_b = 2'b00; m_we = 2'b00;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_be = '0; m1_be = '0;
      repeat (3) @(negedge clk);
      check("rst_ack",   {30'd0, ack_a}, 32'd0);
      check("rst_busy",  {31'd0, busy_a}, 32'd0);
      check("rst_gnt",   {31'd0, gnt_a}, 32'd0);
      check("rst_dm_en", {31'd0, dm_en_a}, 32'd0);
      check("rst_rdata", rdata_a, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // M0 lw 0x0010, DM latency 1
      clear_cnt(); t0 = cyc;
      single_a(0, 1'b0, 32'h0010, 32'd0, 4'b1111, 1'b0, 32'hDEAD_BEEF, 3);
      check("lw_dm_en_count", dm_cnt_a, 1);
      check("lw_dm_en_cycle", dm_cyc_a, t0 + 1);

      // M0 sw to DM
      clear_cnt();
      single_a(0, 1'b1, 32'h0020, 32'h1234_5678, 4'b1111, 1'b0, 32'd0, 2);
      check("sw_dm_we_count", dm_we_cnt_a, 1);

      // M1 sw to TC0 data register
      clear_cnt();
      single_a(1, 1'b1, 32'h7F04, 32'd5, 4'b1111, 1'b0, 32'd0, 2);
      check("tc0_we_count", tc0_cnt_a, 1);
      check("tc_addr",      {2'b00, tc_addr_seen}, 32'h1FC1);
      check("tc_wdata",     tc_wdata_seen, 32'd5);
      check("tc0_dm_quiet", dm_cnt_a, 0);
      check("tc0_tc1_quiet", tc1_cnt_a, 0);

      // M0 lw from TC1
      clear_cnt();
      single_a(0, 1'b0, 32'h7F14, 32'd0, 4'b1111, 1'b0, TC1_RD, 2);
      check("tc1_ld_no_strobe", dm_cnt_a + tc0_cnt_a + tc1_cnt_a, 0);

      // Rejected accesses
      clear_cnt();
      single_a(0, 1'b1, 32'h7F18, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'd0, 2);
      single_a(0, 1'b0, 32'h7F01, 32'd0, 4'b0010, 1'b1, 32'd0, 2);
      single_a(0, 1'b0, 32'h3000, 32'd0, 4'b1111, 1'b1, 32'd0, 2);
      single_a(1, 1'b0, 32'h0001, 32'd0, 4'b1111, 1'b1, 32'd0, 2);
      check("err_no_strobe", dm_cnt_a + tc0_cnt_a + tc1_cnt_a, 0);

      // Both masters hold stores: grants alternate 0,1,0,1 three cycles apart
      clear_cnt();
      set_m(0, 1'b1, 32'h0100, 32'hAAAA_0000, 4'b1111);
      set_m(1, 1'b1, 32'h0200, 32'hBBBB_0000, 4'b1111);
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         e.id = i % 2; e.err = 1'b0; e.rdata = 32'd0; e.cyc = t0 + 2 + 3 * i;
         q_a.push_back(e);
      end
      req_a = 2'b11;
      repeat (11) @(negedge clk);
      req_a = 2'b00;
      repeat (3) @(negedge clk);
      check("rr_dm_we_count", dm_we_cnt_a, 4);

      // Reset while waiting on DM read data
      set_m(0, 1'b0, 32'h0010, 32'd0, 4'b1111);
      req_a = 2'b01;
      repeat (2) @(negedge clk);
      check("dwait_busy", {31'd0, busy_a}, 32'd1);
      reset = 1'b0;
      req_a = 2'b00;
      #1;
      check("arst_ack",     {30'd0, ack_a}, 32'd0);
      check("arst_busy",    {31'd0, busy_a}, 32'd0);
      check("arst_gnt",     {31'd0, gnt_a}, 32'd0);
      check("arst_dm_en",   {31'd0, dm_en_a}, 32'd0);
      check("arst_dm_addr", dm_addr_a, 32'd0);
      check("arst_rdata",   rdata_a, 32'd0);
      check("arst_err",     {31'd0, err_a}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // First tie after reset goes to M0
      set_m(0, 1'b1, 32'h0040, 32'h0000_0011, 4'b1111);
      set_m(1, 1'b1, 32'h0044, 32'h0000_0022, 4'b1111);
      t0 = cyc;
      e.id = 0; e.err = 1'b0; e.rdata = 32'd0; e.cyc = t0 + 2; q_a.push_back(e);
      e.id = 1; e.cyc = t0 + 5; q_a.push_back(e);
      req_a = 2'b11;
      repeat (2) @(negedge clk);
      req_a[0] = 1'b0;
      repeat (3) @(negedge clk);
      req_a[1] = 1'b0;
      repeat (3) @(negedge clk);

      // DM latency 2: M1 lhu 0x0002
      clear_cnt();
      set_m(1, 1'b0, 32'h0002, 32'd0, 4'b1100);
      t0 = cyc;
      e.id = 1; e.err = 1'b0; e.rdata = dm_fn(32'h0002); e.cyc = t0 + 4; q_b.push_back(e);
      req_b = 2'b10;
      repeat (4) @(negedge clk);
      req_b = 2'b00;
      repeat (3) @(negedge clk);
      check("lat2_dm_en_cycle", dm_cyc_b, t0 + 1);

      check("a_missing_acks", q_a.size(), 0);
      check("b_missing_acks", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
